// File: rtl/id_ex_stage_register_if.sv
// Bus between the ID stage and the ID/EX register: decoded fields in, registered copies out.
interface id_ex_stage_register_if #(parameter int NBits = 32);
   logic             in_Valid, in_UsesRt, in_ShamtSelector, in_ALUSrc;
   logic [2:0]       in_ALUOp;
   logic [5:0]       in_ALUFunction;
   logic             in_MemRead, in_MemWrite, in_RegWrite, in_MemtoReg, in_Branch, in_Jump;
   logic [NBits-1:0] in_ReadData1, in_ReadData2, in_Immediate, in_PC_4;
   logic [4:0]       in_Shamt, in_Rs, in_Rt, in_Rd;
   logic [25:0]      in_JumpNoShifted;

   logic             out_Valid, out_ShamtSelector, out_ALUSrc;
   logic [2:0]       out_ALUOp;
   logic [5:0]       out_ALUFunction;
   logic             out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg, out_Branch, out_Jump;
   logic [NBits-1:0] out_ReadData1, out_ReadData2, out_Immediate, out_PC_4;
   logic [4:0]       out_Shamt, out_Rs, out_Rt, out_Rd;
   logic [25:0]      out_JumpNoShifted;

   modport master (
      output in_Valid, in_UsesRt, in_ShamtSelector, in_ALUSrc, in_ALUOp, in_ALUFunction,
             in_MemRead, in_MemWrite, in_RegWrite, in_MemtoReg, in_Branch, in_Jump,
             in_ReadData1, in_ReadData2, in_Immediate, in_PC_4, in_Shamt, in_Rs, in_Rt,
             in_Rd, in_JumpNoShifted,
      input  out_Valid, out_ShamtSelector, out_ALUSrc, out_ALUOp, out_ALUFunction,
             out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg, out_Branch, out_Jump,
             out_ReadData1, out_ReadData2, out_Immediate, out_PC_4, out_Shamt, out_Rs,
             out_Rt, out_Rd, out_JumpNoShifted
   );

   modport slave (
      input  in_Valid, in_UsesRt, in_ShamtSelector, in_ALUSrc, in_ALUOp, in_ALUFunction,
             in_MemRead, in_MemWrite, in_RegWrite, in_MemtoReg, in_Branch, in_Jump,
             in_ReadData1, in_ReadData2, in_Immediate, in_PC_4, in_Shamt, in_Rs, in_Rt,
             in_Rd, in_JumpNoShifted,
      output out_Valid, out_ShamtSelector, out_ALUSrc, out_ALUOp, out_ALUFunction,
             out_MemRead, out_MemWrite, out_RegWrite, out_MemtoReg, out_Branch, out_Jump,
             out_ReadData1, out_ReadData2, out_Immediate, out_PC_4, out_Shamt, out_Rs,
             out_Rt, out_Rd, out_JumpNoShifted
   );
endinterface

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling and
// a saturating bubble counter.
module id_ex_stage_register #(
   parameter int NBits   = 32,
   parameter int CntBits = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Flush,
   input  logic               StallIn,
   output logic               PCWrite,
   output logic               IFIDWrite,
   output logic [CntBits-1:0] BubbleCount,
   id_ex_stage_register_if.slave bus
);
   typedef struct packed {
      logic             valid, shamt_sel, alu_src;
      logic [2:0]       alu_op;
      logic [5:0]       alu_func;
      logic             mem_read, mem_write, reg_write, mem_to_reg, branch, jump;
      logic [NBits-1:0] rd1, rd2, imm, pc_4;
      logic [4:0]       shamt, rs, rt, rd;
      logic [25:0]      jtarget;
   } id_ex_t;

   id_ex_t q, load_v;
   logic   hazard;

   // Only the load sitting in EX can hazard; a load to $0 never produces data.
   assign hazard = bus.in_Valid & q.valid & q.mem_read & (q.rt != 5'd0) &
                   ((q.rt == bus.in_Rs) | (bus.in_UsesRt & (q.rt == bus.in_Rt)));

   // Fetch redirection on Flush beats the hazard stall; a downstream stall beats both.
   assign PCWrite   = ~StallIn & (Flush | ~hazard);
   assign IFIDWrite = ~StallIn & (Flush | ~hazard);

   always_comb begin
      load_v            = '0;
      load_v.valid      = bus.in_Valid;
      load_v.shamt_sel  = bus.in_ShamtSelector;
      load_v.alu_src    = bus.in_ALUSrc;
      load_v.alu_op     = bus.in_ALUOp;
      load_v.alu_func   = bus.in_ALUFunction;
      load_v.mem_to_reg = bus.in_MemtoReg;
      load_v.rd1        = bus.in_ReadData1;
      load_v.rd2        = bus.in_ReadData2;
      load_v.imm        = bus.in_Immediate;
      load_v.pc_4       = bus.in_PC_4;
      load_v.shamt      = bus.in_Shamt;
      load_v.rs         = bus.in_Rs;
      load_v.rt         = bus.in_Rt;
      load_v.rd         = bus.in_Rd;
      load_v.jtarget    = bus.in_JumpNoShifted;
      // Side-effecting controls only pass through for a real instruction.
      if (bus.in_Valid) begin
         load_v.mem_read  = bus.in_MemRead;
         load_v.mem_write = bus.in_MemWrite;
         load_v.reg_write = bus.in_RegWrite;
         load_v.branch    = bus.in_Branch;
         load_v.jump      = bus.in_Jump;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        q <= '0;
      else if (Flush)    q <= '0;
      else if (!StallIn) q <= hazard ? '0 : load_v;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         BubbleCount <= '0;
      else if (!Flush && !StallIn && hazard && !(&BubbleCount))
         BubbleCount <= BubbleCount + CntBits'(1);
   end

   assign bus.out_Valid         = q.valid;
   assign bus.out_ShamtSelector = q.shamt_sel;
   assign bus.out_ALUSrc        = q.alu_src;
   assign bus.out_ALUOp         = q.alu_op;
   assign bus.out_ALUFunction   = q.alu_func;
   assign bus.out_MemRead       = q.mem_read;
   assign bus.out_MemWrite      = q.mem_write;
   assign bus.out_RegWrite      = q.reg_write;
   assign bus.out_MemtoReg      = q.mem_to_reg;
   assign bus.out_Branch        = q.branch;
   assign bus.out_Jump          = q.jump;
   assign bus.out_ReadData1     = q.rd1;
   assign bus.out_ReadData2     = q.rd2;
   assign bus.out_Immediate     = q.imm;
   assign bus.out_PC_4          = q.pc_4;
   assign bus.out_Shamt         = q.shamt;
   assign bus.out_Rs            = q.rs;
   assign bus.out_Rt            = q.rt;
   assign bus.out_Rd            = q.rd;
   assign bus.out_JumpNoShifted = q.jtarget;
endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed and randomized checks of the ID/EX register against a behavioural model.
module tb_id_ex_stage_register;
   localparam int NB = 32;
   localparam int CB = 4;

   typedef struct packed {
      logic          Valid, ShamtSelector, ALUSrc;
      logic [2:0]    ALUOp;
      logic [5:0]    ALUFunction;
      logic          MemRead, MemWrite, RegWrite, MemtoReg, Branch, Jump;
      logic [NB-1:0] ReadData1, ReadData2, Immediate, PC_4;
      logic [4:0]    Shamt, Rs, Rt, Rd;
      logic [25:0]   JumpNoShifted;
   } f_t;

   logic          clk = 0;
   logic          reset = 0;
   logic          flush = 0, stall_in = 0, uses_rt = 0;
   logic          pc_write, ifid_write;
   logic [CB-1:0] bubble_count;
   f_t            drv = '0;
   f_t            m = '0;
   int            mcnt = 0;
   int            vec = 0, fails = 0;
   bit            cmp_on = 0;

   id_ex_stage_register_if #(.NBits(NB)) bus ();

   id_ex_stage_register #(.NBits(NB), .CntBits(CB)) dut (
      .clk(clk), .reset(reset), .Flush(flush), .StallIn(stall_in),
      .PCWrite(pc_write), .IFIDWrite(ifid_write), .BubbleCount(bubble_count),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.in_Valid = drv.Valid;                 assign bus.in_UsesRt = uses_rt;
   assign bus.in_ShamtSelector = drv.ShamtSelector; assign bus.in_ALUSrc = drv.ALUSrc;
   assign bus.in_ALUOp = drv.ALUOp;                 assign bus.in_ALUFunction = drv.ALUFunction;
   assign bus.in_MemRead = drv.MemRead;             assign bus.in_MemWrite = drv.MemWrite;
   assign bus.in_RegWrite = drv.RegWrite;           assign bus.in_MemtoReg = drv.MemtoReg;
   assign bus.in_Branch = drv.Branch;               assign bus.in_Jump = drv.Jump;
   assign bus.in_ReadData1 = drv.ReadData1;         assign bus.in_ReadData2 = drv.ReadData2;
   assign bus.in_Immediate = drv.Immediate;         assign bus.in_PC_4 = drv.PC_4;
   assign bus.in_Shamt = drv.Shamt;                 assign bus.in_Rs = drv.Rs;
   assign bus.in_Rt = drv.Rt;                       assign bus.in_Rd = drv.Rd;
   assign bus.in_JumpNoShifted = drv.JumpNoShifted;

   function automatic f_t actual();
      f_t a;
      a.Valid = bus.out_Valid;               a.ShamtSelector = bus.out_ShamtSelector;
      a.ALUSrc = bus.out_ALUSrc;             a.ALUOp = bus.out_ALUOp;
      a.ALUFunction = bus.out_ALUFunction;   a.MemRead = bus.out_MemRead;
      a.MemWrite = bus.out_MemWrite;         a.RegWrite = bus.out_RegWrite;
      a.MemtoReg = bus.out_MemtoReg;         a.Branch = bus.out_Branch;
      a.Jump = bus.out_Jump;                 a.ReadData1 = bus.out_ReadData1;
      a.ReadData2 = bus.out_ReadData2;       a.Immediate = bus.out_Immediate;
      a.PC_4 = bus.out_PC_4;                 a.Shamt = bus.out_Shamt;
      a.Rs = bus.out_Rs;                     a.Rt = bus.out_Rt;
      a.Rd = bus.out_Rd;                     a.JumpNoShifted = bus.out_JumpNoShifted;
      return a;
   endfunction

   // Load-use rule evaluated on the model's view of what sits in EX.
   function automatic bit model_hazard();
      return drv.Valid && m.Valid && m.MemRead && (m.Rt != 0) &&
             ((m.Rt == drv.Rs) || (uses_rt && (m.Rt == drv.Rt)));
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m = '0; mcnt = 0;
      end else if (flush) begin
         m = '0;
      end else if (!stall_in) begin
         if (model_hazard()) begin
            m = '0;
            mcnt = (mcnt + 1 > (1 << CB) - 1) ? (1 << CB) - 1 : mcnt + 1;
         end else begin
            m = drv;
            if (!drv.Valid) {m.MemRead, m.MemWrite, m.RegWrite, m.Branch, m.Jump} = '0;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         f_t a;
         logic exp_pw;
         a = actual();
         exp_pw = !stall_in && (flush || !model_hazard());
         vec++;
         if (a !== m) begin
            fails++;
            $display("FAIL regs t=%0t: got %h expected %h", $time, a, m);
         end
         vec++;
         if (pc_write !== exp_pw || ifid_write !== exp_pw) begin
            fails++;
            $display("FAIL enables t=%0t: got pc=%b ifid=%b expected %b", $time, pc_write, ifid_write, exp_pw);
         end
         vec++;
         if (int'(bubble_count) != mcnt) begin
            fails++;
            $display("FAIL bubble_count t=%0t: got %0d expected %0d", $time, bubble_count, mcnt);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
      drv = '0; uses_rt = 0;
      drv.Valid = 1; drv.MemRead = 1; drv.RegWrite = 1; drv.MemtoReg = 1; drv.ALUSrc = 1;
      drv.Rs = rs; drv.Rt = rt; drv.Rd = rt; drv.Immediate = 32'h10;
   endtask

   task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [NB-1:0] a, input logic [NB-1:0] b);
      drv = '0; uses_rt = 1;
      drv.Valid = 1; drv.ALUOp = 3'b010; drv.ALUFunction = 6'h20; drv.RegWrite = 1;
      drv.Rs = rs; drv.Rt = rt; drv.Rd = rd; drv.ReadData1 = a; drv.ReadData2 = b;
   endtask

   initial begin
      tick(); tick();
      reset = 1; cmp_on = 1;
      chk("reset_valid", bus.out_Valid, 0);
      chk("reset_count", bubble_count, 0);

      // Normal flow
      set_add(1, 2, 8, 32'h5, 32'h7);
      tick();
      chk("add_func", bus.out_ALUFunction, 6'h20);
      chk("add_rd1", bus.out_ReadData1, 5);
      chk("add_rd", bus.out_Rd, 8);
      chk("add_regwr", bus.out_RegWrite, 1);
      chk("add_valid", bus.out_Valid, 1);

      // Load-use
      set_lw(1, 8); tick();
      set_add(8, 3, 4, 32'h1, 32'h2); #1;
      chk("lu_pcwrite", pc_write, 0);
      chk("lu_ifidwrite", ifid_write, 0);
      tick();
      chk("lu_bubble_valid", bus.out_Valid, 0);
      chk("lu_count", bubble_count, 1);
      chk("lu_resume_pcwrite", pc_write, 1);
      tick();
      chk("lu_add_valid", bus.out_Valid, 1);
      chk("lu_add_rs", bus.out_Rs, 8);

      // Load to $0 never stalls
      set_lw(1, 0); tick();
      set_add(0, 0, 4, 32'h1, 32'h2); #1;
      chk("r0_pcwrite", pc_write, 1);

      // UsesRt gating, then Flush overriding the hazard
      set_lw(1, 9); tick();
      drv.Valid = 1; drv.MemRead = 0; drv.RegWrite = 1; drv.ALUSrc = 1; drv.Rs = 1; drv.Rt = 9;
      uses_rt = 0; #1;
      chk("usesrt0_pcwrite", pc_write, 1);
      uses_rt = 1; #1;
      chk("usesrt1_pcwrite", pc_write, 0);
      flush = 1; #1;
      chk("flush_pcwrite", pc_write, 1);
      chk("flush_ifidwrite", ifid_write, 1);
      tick();
      flush = 0;
      chk("flush_valid", bus.out_Valid, 0);
      chk("flush_memread", bus.out_MemRead, 0);
      chk("flush_count", bubble_count, 1);

      // Downstream stall freezes the register
      set_add(2, 3, 4, 32'hAAAA, 32'hBBBB); tick();
      stall_in = 1; #1;
      chk("stall_pcwrite", pc_write, 0);
      for (int i = 0; i < 3; i++) begin
         drv.ReadData1 = $urandom; drv.Rd = 5'(i + 10);
         tick();
         chk("stall_hold_rd1", bus.out_ReadData1, 32'hAAAA);
      end
      stall_in = 0; drv.ReadData1 = 32'h1234;
      tick();
      chk("stall_release_rd1", bus.out_ReadData1, 32'h1234);

      // Counter saturation
      for (int i = 0; i < 16; i++) begin
         set_lw(1, 5); tick();
         set_add(5, 1, 2, 32'h0, 32'h0); tick();
      end
      chk("sat_count", bubble_count, 4'hF);

      // Asynchronous reset mid-run
      set_add(1, 2, 3, 32'h9, 32'h9); tick();
      chk("prereset_valid", bus.out_Valid, 1);
      reset = 0; #1;
      chk("areset_valid", bus.out_Valid, 0);
      chk("areset_count", bubble_count, 0);
      chk("areset_pcwrite", pc_write, 1);
      chk("areset_ifidwrite", ifid_write, 1);
      tick();
      reset = 1;

      // Randomized traffic with a small register space so hazards are frequent
      for (int i = 0; i < 600; i++) begin
         drv.Valid = ($urandom % 8) != 0;
         {drv.ShamtSelector, drv.ALUSrc, drv.MemWrite, drv.RegWrite} = 4'($urandom);
         {drv.MemtoReg, drv.Branch, drv.Jump} = 3'($urandom);
         drv.MemRead = ($urandom % 2) != 0;
         drv.ALUOp = 3'($urandom); drv.ALUFunction = 6'($urandom);
         drv.ReadData1 = $urandom; drv.ReadData2 = $urandom;
         drv.Immediate = $urandom; drv.PC_4 = $urandom;
         drv.Shamt = 5'($urandom); drv.JumpNoShifted = 26'($urandom);
         drv.Rs = 5'($urandom % 4); drv.Rt = 5'($urandom % 4); drv.Rd = 5'($urandom % 4);
         uses_rt = ($urandom % 2) != 0;
         flush = ($urandom % 10) == 0;
         stall_in = ($urandom % 7) == 0;
         tick();
      end
      flush = 0; stall_in = 0;
      tick();
      cmp_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
      $finish;
   end
endmodule

// File: doc/id_ex_stage_register.md
Name: id_ex_stage_register

Overview:
Pipeline register between instruction decode (ID) and execute (EX) in the 5-stage MIPS core. It also contains the load-use hazard detector. It captures decoded control and operands each cycle, inserts bubbles on load-use hazards and branch/jump flushes, and holds state on downstream stalls. It drives the PC/IF-ID write enables and exposes a saturating bubble counter for performance debug.

Parameters:
NBits, 32, datapath width (PC, register data, immediate)
CntBits, 16, width of bubble counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
in_Valid  input  1  ID holds a real instruction
in_UsesRt  input  1  ID instruction reads Rt as a source (R-type, store, beq/bne)
in_ShamtSelector  input  1  EX A-operand = shamt
in_ALUSrc  input  1  EX B-operand = immediate
in_ALUOp  input  3  ALU control opcode
in_ALUFunction  input  6  funct field
in_MemRead  input  1  load
in_MemWrite  input  1  store
in_RegWrite  input  1  writes register file
in_MemtoReg  input  1  writeback selects memory data
in_Branch  input  1  conditional branch
in_Jump  input  1  jump
in_ReadData1  input  NBits  rs data
in_ReadData2  input  NBits  rt data
in_Immediate  input  NBits  sign-extended immediate
in_Shamt  input  5  shift amount
in_JumpNoShifted  input  26  jump target field
in_PC_4  input  NBits  PC+4
in_Rs, in_Rt, in_Rd  input  5 each  register specifiers (in_Rd = already-selected destination)
Flush  input  1  branch/jump taken in EX; squash ID and ID/EX
StallIn  input  1  downstream (MEM) stall; hold
out_* (one per in_* above except in_UsesRt)  output  same width  registered copies
out_Valid  output  1  registered valid
PCWrite  output  1  PC write enable (combinational)
IFIDWrite  output  1  IF/ID register write enable (combinational)
BubbleCount  output  CntBits  saturating count of hazard bubbles

Behaviour:
- reset low (asynchronous): every out_* register = 0 and out_Valid = 0; BubbleCount = 0. Combinational outputs evaluate with register contents = 0, so PCWrite = IFIDWrite = 1 unless StallIn.
- Hazard = in_Valid & out_Valid & out_MemRead & (out_Rt != 0) & ((out_Rt == in_Rs) | (in_UsesRt & out_Rt == in_Rt)).
- Per-edge update priority, highest first:
  1. Flush: load a bubble. Bubble = out_Valid 0, all control outputs 0 (MemWrite, RegWrite, Branch, Jump, MemRead 0). Data fields are cleared to 0.
  2. StallIn: hold every register.
  3. Hazard: load a bubble; BubbleCount += 1, saturating at all-ones.
  4. Otherwise: load all in_* fields. out_Valid = in_Valid. If in_Valid = 0, control is forced to 0 (same as bubble).
- PCWrite = IFIDWrite = ~StallIn & (Flush | ~Hazard). During Flush, fetch redirection takes priority over the hazard stall.
- Simultaneous Flush + StallIn: Flush wins in this register. Upstream enables still follow ~StallIn.
- Latency: one cycle ID to EX for a normal load. A load-use hazard costs exactly one bubble. On the next cycle the load has moved on, so the hazard clears and the instruction loads.
- A write to register $0 never causes a hazard.
- No state machine beyond the valid bit. The bubble counter never wraps.

Test Plan:
- Reset: hold reset low mid-run with out_Valid = 1 -> all outputs 0, BubbleCount = 0, PCWrite = IFIDWrite = 1 immediately (asynchronous).
- Normal flow: in_Valid = 1, add with ReadData1 = 0x5, ReadData2 = 0x7, Rd = 8 -> next edge out_ALUFunction = 0x20, out_ReadData1 = 5, out_Rd = 8, out_RegWrite = 1, out_Valid = 1.
- Load-use: lw $t0 (Rt = 8) in ID/EX, then ID add with Rs = 8 -> PCWrite = IFIDWrite = 0 for one cycle, bubble loaded, BubbleCount = 1. Next cycle the add loads. Repeat with Rt = 0 -> no stall.
- UsesRt gating: lw Rt = 9 in ID/EX; ID addi with Rt = 9, in_UsesRt = 0 -> no stall. Same with in_UsesRt = 1 -> stall.
- Flush vs hazard: hazard condition true and Flush = 1 -> bubble loaded, PCWrite = 1, BubbleCount unchanged.
- StallIn: StallIn = 1 for 3 cycles with changing inputs -> outputs frozen, PCWrite = IFIDWrite = 0. Release -> current inputs load. Additionally, preload BubbleCount near all-ones (CntBits = 4 build, 16 hazards) -> saturates at 0xF.
